// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter for register_file_v1: round-robin over N_REQ requesters onto two write ports.
// A zeroing walk clears x0..x31 after reset. Define REGFILE_ARB_STATS_EN for conflict/grant counters.
module regfile_wb_arbiter #(
  parameter int N_REQ     = 4,
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 5,
  parameter int INIT_ZERO = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  input  logic                    hold,
  output logic [ADDR_W-1:0]       rf_reg_addr1,
  output logic [ADDR_W-1:0]       rf_reg_addr2,
  output logic [DATA_W-1:0]       rf_wr_data1,
  output logic [DATA_W-1:0]       rf_wr_data2,
  output logic [1:0]              rf_rdwr_config,
  output logic                    rf_link_reg,
`ifdef REGFILE_ARB_STATS_EN
  output logic [15:0]             conflict_cnt,
  output logic [15:0]             grant_cnt,
`endif
  output logic                    init_done
);
  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t state, state_nxt;
  logic [3:0]    k;
  logic [PW-1:0] rr_ptr, rr_nxt, last_idx;
  logic [N_REQ-1:0][ADDR_W-1:0] addr_v;
  logic [N_REQ-1:0][DATA_W-1:0] data_v;

  logic          found_a, found_b;
  logic [PW-1:0] a_idx, b_idx;
`ifdef REGFILE_ARB_STATS_EN
  logic          conflict;
  logic [16:0]   grant_sum;
`endif

  assign addr_v      = req_addr;
  assign data_v      = req_data;
  assign rf_link_reg = 1'b0;

  always_comb begin
    state_nxt = state;
    if (state == S_INIT && k == 4'd15) state_nxt = S_RUN;
  end

  // Single rotating scan: first valid is A; next valid with a different (or zero) addr is B.
  always_comb begin
    int idx;
    req_ready = '0;
    found_a   = 1'b0;
    found_b   = 1'b0;
    a_idx     = '0;
    b_idx     = '0;
    idx       = 0;
`ifdef REGFILE_ARB_STATS_EN
    conflict  = 1'b0;
`endif
    if (rst && state == S_RUN && !hold) begin
      for (int j = 0; j < N_REQ; j++) begin
        idx = int'(rr_ptr) + j;
        if (idx >= N_REQ) idx = idx - N_REQ;
        if (req_valid[idx]) begin
          if (!found_a) begin
            found_a        = 1'b1;
            a_idx          = PW'(idx);
            req_ready[idx] = 1'b1;
          end else if (!found_b) begin
            if (addr_v[idx] != addr_v[a_idx] || addr_v[idx] == '0) begin
              found_b        = 1'b1;
              b_idx          = PW'(idx);
              req_ready[idx] = 1'b1;
            end
`ifdef REGFILE_ARB_STATS_EN
            else conflict = 1'b1;
`endif
          end
        end
      end
    end
  end

  assign last_idx = found_b ? b_idx : a_idx;
  assign rr_nxt   = (last_idx == PW'(N_REQ-1)) ? '0 : last_idx + 1'b1;

`ifdef REGFILE_ARB_STATS_EN
  assign grant_sum = {1'b0, grant_cnt} + {15'd0, found_a} + {15'd0, found_b};
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= (INIT_ZERO != 0) ? S_INIT : S_RUN;
      k              <= '0;
      rr_ptr         <= '0;
      rf_reg_addr1   <= '0;
      rf_reg_addr2   <= '0;
      rf_wr_data1    <= '0;
      rf_wr_data2    <= '0;
      rf_rdwr_config <= '0;
      init_done      <= 1'b0;
`ifdef REGFILE_ARB_STATS_EN
      conflict_cnt   <= '0;
      grant_cnt      <= '0;
`endif
    end else begin
      state <= state_nxt;
      if (state == S_INIT) begin
        rf_reg_addr1   <= ADDR_W'({k, 1'b0});
        rf_reg_addr2   <= ADDR_W'({k, 1'b1});
        rf_wr_data1    <= '0;
        rf_wr_data2    <= '0;
        rf_rdwr_config <= 2'b11;
        k              <= k + 1'b1;
        if (k == 4'd15) init_done <= 1'b1;
      end else begin
        init_done <= 1'b1;
        // addr-0 grants are consumed but never write; ungranted ports keep addr/data
        rf_rdwr_config <= {found_b && addr_v[b_idx] != '0, found_a && addr_v[a_idx] != '0};
        if (found_a) begin
          rf_reg_addr1 <= addr_v[a_idx];
          rf_wr_data1  <= data_v[a_idx];
          rr_ptr       <= rr_nxt;
        end
        if (found_b) begin
          rf_reg_addr2 <= addr_v[b_idx];
          rf_wr_data2  <= data_v[b_idx];
        end
`ifdef REGFILE_ARB_STATS_EN
        if (conflict && conflict_cnt != 16'hFFFF) conflict_cnt <= conflict_cnt + 1'b1;
        grant_cnt <= grant_sum[16] ? 16'hFFFF : grant_sum[15:0];
`endif
      end
    end
  end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: init walk, round-robin pairing, conflicts, addr 0, hold, async reset.
module tb_regfile_wb_arbiter;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic hold = 1'b0;
  logic [N-1:0] req_valid = '0;
  logic [N-1:0] req_ready;
  logic [N-1:0][4:0]  addr_v = '0;
  logic [N-1:0][31:0] data_v = '0;
  logic [4:0]  rf_reg_addr1, rf_reg_addr2;
  logic [31:0] rf_wr_data1, rf_wr_data2;
  logic [1:0]  rf_rdwr_config;
  logic        rf_link_reg, init_done;
`ifdef REGFILE_ARB_STATS_EN
  logic [15:0] conflict_cnt, grant_cnt;
`endif

  int passed = 0;
  int total  = 0;

  regfile_wb_arbiter #(.N_REQ(N), .DATA_W(32), .ADDR_W(5), .INIT_ZERO(1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(addr_v), .req_data(data_v), .hold(hold),
    .rf_reg_addr1(rf_reg_addr1), .rf_reg_addr2(rf_reg_addr2),
    .rf_wr_data1(rf_wr_data1), .rf_wr_data2(rf_wr_data2),
    .rf_rdwr_config(rf_rdwr_config), .rf_link_reg(rf_link_reg),
`ifdef REGFILE_ARB_STATS_EN
    .conflict_cnt(conflict_cnt), .grant_cnt(grant_cnt),
`endif
    .init_done(init_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1 rst = 1'b0;
    #1;
    chk("rst_addr1", rf_reg_addr1, 0);
    chk("rst_addr2", rf_reg_addr2, 0);
    chk("rst_data1", rf_wr_data1, 0);
    chk("rst_cfg", rf_rdwr_config, 0);
    chk("rst_link", rf_link_reg, 0);
    chk("rst_done", init_done, 0);
    for (int i = 0; i < N; i++) addr_v[i] = 5'(i + 1);
    req_valid = '1;
    #1 chk("rst_ready", req_ready, 0);

    // init walk: 16 pairs (2k, 2k+1), zero data, both enables
    @(negedge clk) rst = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("init_ready", req_ready, 0);
      tick();
      chk("init_addr1", rf_reg_addr1, 2 * i);
      chk("init_addr2", rf_reg_addr2, 2 * i + 1);
      chk("init_data", {rf_wr_data1, rf_wr_data2}, 0);
      chk("init_cfg", rf_rdwr_config, 2'b11);
      chk("init_done", init_done, (i == 15) ? 1 : 0);
    end

    // single write, rr_ptr=0
    req_valid = 4'b0001; addr_v[0] = 5; data_v[0] = 32'hDEADBEEF;
    #1 chk("t2_ready", req_ready, 4'b0001);
    tick(); req_valid = '0;
    chk("t2_addr1", rf_reg_addr1, 5);
    chk("t2_data1", rf_wr_data1, 32'hDEADBEEF);
    chk("t2_cfg", rf_rdwr_config, 2'b01);
    tick();
    chk("t2_idle_cfg", rf_rdwr_config, 2'b00);

    // rr_ptr=1: lone req3 wraps rr_ptr back to 0
    req_valid = 4'b1000; addr_v[3] = 9; data_v[3] = 32'h33;
    #1 chk("p3_ready", req_ready, 4'b1000);
    tick(); req_valid = '0;
    chk("p3_addr1", rf_reg_addr1, 9);
    chk("p3_cfg", rf_rdwr_config, 2'b01);

    // four distinct addrs: two pairs
    for (int i = 0; i < N; i++) begin addr_v[i] = 5'(i + 1); data_v[i] = 32'h10 + i; end
    req_valid = 4'b1111;
    #1 chk("t3_ready_a", req_ready, 4'b0011);
    tick();
    chk("t3_addr1_a", rf_reg_addr1, 1);
    chk("t3_data1_a", rf_wr_data1, 32'h10);
    chk("t3_addr2_a", rf_reg_addr2, 2);
    chk("t3_data2_a", rf_wr_data2, 32'h11);
    chk("t3_cfg_a", rf_rdwr_config, 2'b11);
    req_valid = 4'b1100;
    #1 chk("t3_ready_b", req_ready, 4'b1100);
    tick(); req_valid = '0;
    chk("t3_addr1_b", rf_reg_addr1, 3);
    chk("t3_addr2_b", rf_reg_addr2, 4);
    chk("t3_data2_b", rf_wr_data2, 32'h13);
    chk("t3_cfg_b", rf_rdwr_config, 2'b11);

    // same-addr conflict, rr_ptr=0
    addr_v[0] = 7; addr_v[1] = 7; data_v[0] = 32'hA0; data_v[1] = 32'hA1;
    req_valid = 4'b0011;
    #1 chk("t4_ready_a", req_ready, 4'b0001);
    tick(); req_valid = 4'b0010;
    chk("t4_addr1_a", rf_reg_addr1, 7);
    chk("t4_data1_a", rf_wr_data1, 32'hA0);
    chk("t4_cfg_a", rf_rdwr_config, 2'b01);
    chk("t4_addr2_hold", rf_reg_addr2, 4);
    #1 chk("t4_ready_b", req_ready, 4'b0010);
    tick(); req_valid = '0;
    chk("t4_data1_b", rf_wr_data1, 32'hA1);
    chk("t4_cfg_b", rf_rdwr_config, 2'b01);
`ifdef REGFILE_ARB_STATS_EN
    chk("t4_conflict_cnt", conflict_cnt, 1);
    chk("t4_grant_cnt", grant_cnt, 8);
`endif

    // addr 0: accepted, no write enable, rr_ptr=2
    req_valid = 4'b0100; addr_v[2] = 0; data_v[2] = 32'h55;
    #1 chk("t5_ready", req_ready, 4'b0100);
    tick(); req_valid = '0;
    chk("t5_cfg", rf_rdwr_config, 2'b00);
    chk("t5_addr1", rf_reg_addr1, 0);
    chk("t5_data1", rf_wr_data1, 32'h55);
`ifdef REGFILE_ARB_STATS_EN
    chk("t5_grant_cnt", grant_cnt, 9);
`endif

    // hold freezes grants; release, then async reset mid-RUN
    hold = 1'b1; req_valid = 4'b0001; addr_v[0] = 6; data_v[0] = 32'h66;
    for (int i = 0; i < 3; i++) begin
      #1 chk("t6_hold_ready", req_ready, 0);
      tick();
      chk("t6_hold_cfg", rf_rdwr_config, 2'b00);
    end
    hold = 1'b0;
    #1 chk("t6_rel_ready", req_ready, 4'b0001);
    tick();
    chk("t6_rel_addr1", rf_reg_addr1, 6);
    chk("t6_rel_cfg", rf_rdwr_config, 2'b01);
    #2 rst = 1'b0;
    #1;
    chk("t6_rst_addr", {rf_reg_addr1, rf_reg_addr2}, 0);
    chk("t6_rst_data", {rf_wr_data1, rf_wr_data2}, 0);
    chk("t6_rst_cfg", rf_rdwr_config, 0);
    chk("t6_rst_done", init_done, 0);
    chk("t6_rst_ready", req_ready, 0);
`ifdef REGFILE_ARB_STATS_EN
    chk("t6_rst_stats", {conflict_cnt, grant_cnt}, 0);
`endif
    @(negedge clk) rst = 1'b1;
    #1 chk("t6_walk_ready", req_ready, 0);
    tick();
    chk("t6_walk_addr1_0", rf_reg_addr1, 0);
    chk("t6_walk_addr2_0", rf_reg_addr2, 1);
    chk("t6_walk_cfg", rf_rdwr_config, 2'b11);
    tick();
    chk("t6_walk_addr1_1", rf_reg_addr1, 2);
    chk("t6_walk_addr2_1", rf_reg_addr2, 3);
    chk("t6_walk_done", init_done, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
